// File: rtl/merge_2to1_rr.sv
// merge_2to1_rr: two valid/ready streams merged into one registered output.
// Round-robin arbitration between the channels; once a packet's first beat is
// granted, that channel keeps the grant until its last beat is accepted.
// out_sel tags each output beat with the channel it came from.
module merge_2to1_rr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din0,
  input  logic             last0,
  input  logic             valid0,
  output logic             ready0,
  input  logic [WIDTH-1:0] din1,
  input  logic             last1,
  input  logic             valid1,
  output logic             ready1,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             rr_ptr_r;      // channel that won the most recent packet
  logic             rr_ptr_nxt_s;
  logic             space_s;
  logic             winner_s;
  logic             ready0_s;
  logic             ready1_s;
  logic             accept_s;
  logic             acc_last_s;
  logic [WIDTH-1:0] acc_data_s;

  // The output register can take a beat when it is empty or draining now.
  assign space_s = !out_valid || out_ready;

  // Pick the granted channel and raise its ready; the other channel waits.
  always_comb begin
    winner_s = 1'b0;
    ready0_s = 1'b0;
    ready1_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (valid0 && valid1) begin
          winner_s = !rr_ptr_r;
        end else if (valid1) begin
          winner_s = 1'b1;
        end else begin
          winner_s = 1'b0;
        end
        if (valid0 || valid1) begin
          ready0_s = space_s && !winner_s;
          ready1_s = space_s && winner_s;
        end else begin
          ready0_s = 1'b0;
          ready1_s = 1'b0;
        end
      end
      LOCK0: begin
        winner_s = 1'b0;
        ready0_s = space_s;
      end
      LOCK1: begin
        winner_s = 1'b1;
        ready1_s = space_s;
      end
      default: begin
        winner_s = 1'b0;
        ready0_s = 1'b0;
        ready1_s = 1'b0;
      end
    endcase
  end

  assign ready0   = ready0_s;
  assign ready1   = ready1_s;
  assign accept_s = (valid0 && ready0_s) || (valid1 && ready1_s);

  // Mux the granted channel's beat toward the output register.
  always_comb begin
    acc_data_s = din0;
    acc_last_s = last0;
    if (winner_s) begin
      acc_data_s = din1;
      acc_last_s = last1;
    end else begin
      acc_data_s = din0;
      acc_last_s = last0;
    end
  end

  // Next lock state and round-robin pointer, driven by accepted beats only.
  always_comb begin
    state_nxt_s  = state_r;
    rr_ptr_nxt_s = rr_ptr_r;
    case (state_r)
      IDLE, LOCK0, LOCK1: begin
        if (accept_s) begin
          if (acc_last_s) begin
            state_nxt_s  = IDLE;
            rr_ptr_nxt_s = winner_s;
          end else if (winner_s) begin
            state_nxt_s = LOCK1;
          end else begin
            state_nxt_s = LOCK0;
          end
        end else begin
          state_nxt_s  = state_r;
          rr_ptr_nxt_s = rr_ptr_r;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        rr_ptr_nxt_s = rr_ptr_r;
      end
    endcase
  end

  // Arbiter state register; reset favours channel 0 on the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      rr_ptr_r <= 1'b1;
    end else begin
      state_r  <= state_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  // Output register: load on accept, empty on transfer, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_sel   <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept_s) begin
      out_valid <= 1'b1;
      out_data  <= acc_data_s;
      out_sel   <= winner_s;
      out_last  <= acc_last_s;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_merge_2to1_rr.sv
// Bench for merge_2to1_rr: directed scenarios followed by random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_merge_2to1_rr;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] din0, din1;
  logic             last0, last1, valid0, valid1, ready0, ready1;
  logic [WIDTH-1:0] out_data;
  logic             out_sel, out_last, out_valid, out_ready;

  merge_2to1_rr #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .din0(din0), .last0(last0), .valid0(valid0), .ready0(ready0),
    .din1(din1), .last1(last1), .valid1(valid1), .ready1(ready1),
    .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    bit         s;
    bit         l;
  } beat_t;

  int         n_checks = 0;
  int         n_pass   = 0;
  bit         checks_on = 1'b0;
  bit         watch_r1  = 1'b0;

  // Reference model: beats waiting on the output, the channel holding a
  // packet (-1 = none) and the channel that wins the next tie.
  beat_t      exp_q[$];
  beat_t      seen[$];
  int         owner = -1;
  int         prio  = 0;

  // Per-channel sources: current data, beats left in packet, fixed length (0 = random).
  logic [7:0] gd[2];
  int         grem[2];
  int         fixlen[2];
  int         hs_count = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int new_len(input int k);
    if (fixlen[k] != 0) return fixlen[k];
    return int'($urandom_range(1, 4));
  endfunction

  task automatic step(input bit v0, input bit v1, input bit ordy, input bit r);
    int    g;
    bit    space, er0, er1, acc, xfer;
    beat_t b;
    rst       = r;
    valid0    = v0;
    valid1    = v1;
    out_ready = ordy;
    din0      = gd[0];
    last0     = (grem[0] == 1);
    din1      = gd[1];
    last1     = (grem[1] == 1);
    @(negedge clk);
    space = (exp_q.size() == 0) || ordy;
    g = -1;
    if (owner >= 0)      g = owner;
    else if (v0 && v1)   g = prio;
    else if (v0)         g = 0;
    else if (v1)         g = 1;
    er0  = (g == 0) && space;
    er1  = (g == 1) && space;
    acc  = !r && ((g == 0 && v0 && er0) || (g == 1 && v1 && er1));
    xfer = (exp_q.size() > 0) && ordy;
    if (checks_on) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        check("out_data", 32'(out_data), 32'(exp_q[0].d));
        check("out_sel",  32'(out_sel),  32'(exp_q[0].s));
        check("out_last", 32'(out_last), 32'(exp_q[0].l));
      end
      if (!r) begin
        check("ready0", 32'(ready0), 32'(er0));
        check("ready1", 32'(ready1), 32'(er1));
      end
      if (watch_r1) check("gap_ready1", 32'(ready1), 32'd0);
    end
    if (out_valid === 1'b1 && ordy) begin
      b.d = out_data; b.s = out_sel; b.l = out_last;
      seen.push_back(b);
    end
    if ((v0 && ready0 === 1'b1) || (v1 && ready1 === 1'b1)) hs_count++;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      owner = -1;
      prio  = 0;
    end else begin
      if (xfer) void'(exp_q.pop_front());
      if (acc) begin
        b.d = gd[g]; b.s = (g == 1); b.l = (grem[g] == 1);
        exp_q.push_back(b);
        if (b.l) begin
          owner = -1;
          prio  = 1 - g;
        end else begin
          owner = g;
        end
        gd[g] = gd[g] + 8'd1;
        if (grem[g] == 1) grem[g] = new_len(g);
        else              grem[g] = grem[g] - 1;
      end
    end
    #1;
  endtask

  initial begin
    logic [7:0] t2_exp[4];
    logic [7:0] t3_exp[4];
    t2_exp = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
    t3_exp = '{8'h11, 8'h12, 8'h13, 8'hA2};
    gd[0] = 8'hA0; gd[1] = 8'hB0;
    fixlen[0] = 1; fixlen[1] = 1;
    grem[0] = 1;   grem[1] = 1;
    rst = 1'b1; valid0 = 1'b0; valid1 = 1'b0; out_ready = 1'b0;
    din0 = '0; din1 = '0; last0 = 1'b0; last1 = 1'b0;

    // T1: reset with both channels valid; nothing comes out afterwards.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks_on = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_out_data",  32'(out_data),  32'd0);

    // T2: ties with single-beat packets alternate starting at channel 0.
    seen.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      check("t2_data", 32'(seen[i].d), 32'(t2_exp[i]));
      check("t2_sel",  32'(seen[i].s), 32'(i % 2));
    end

    // T3: channel 1 locks for a 3-beat packet; channel 0 follows.
    gd[1] = 8'h11; fixlen[1] = 3; grem[1] = 3;
    seen.delete();
    step(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_count", 32'(seen.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      check("t3_data", 32'(seen[i].d), 32'(t3_exp[i]));
      check("t3_sel",  32'(seen[i].s), (i < 3) ? 32'd1 : 32'd0);
    end

    // T4: backpressure admits exactly one beat, then traffic resumes.
    fixlen[0] = 0; fixlen[1] = 0;
    hs_count = 0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t4_accepts", 32'(hs_count), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0);

    // T5: idle gap inside a channel-0 packet keeps channel 1 blocked.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    gd[0] = 8'h50; fixlen[0] = 4; grem[0] = 4;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    watch_r1 = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    watch_r1 = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0);

    // T6: reset mid-packet in LOCK0; the next tie goes to channel 0.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    gd[0] = 8'h60; fixlen[0] = 3; grem[0] = 3;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t6_out_sel", 32'(out_sel), 32'd0);

    // Random traffic with occasional resets.
    fixlen[0] = 0; fixlen[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
